muldiv_seq: RTL and testbench
=============================

Name: muldiv_seq

Overview:
- Iterative multiply/divide responder that serves the execute stage's start/stall handshake and owns the HI/LO architectural registers.
- Accepts one operation per start pulse and holds busy for a fixed latency. HI/LO commit on the last busy cycle.
- Exports stall = start | busy so the hazard logic freezes instructions that follow and need HI/LO or the unit.

Parameters:
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (legal 1..15)
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (legal 1..15)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset
- start  in  1  one-cycle request; op/src_a/src_b are sampled when start=1
- op  in  3  001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO, others no-op
- src_a  in  32  rs operand (multiplicand / dividend / MTHI-MTLO data)
- src_b  in  32  rt operand (multiplier / divisor)
- busy  out  1  operation in flight
- stall  out  1  combinational start | busy
- hi  out  32  HI register
- lo  out  32  LO register

Behaviour:
- Reset (reset=0 at a rising edge): state=IDLE, count=0, busy=0, hi=0, lo=0, pending result cleared. Reset takes priority over everything and aborts an in-flight operation. No commit to hi/lo occurs.
- States: IDLE and BUSY.
- IDLE, start=1, op in {MULT, MULTU}:
  - Latch the 64-bit product into pending {ph, pl}.
  - Load count=MULT_CYCLES-1 and go to BUSY. busy=1 from the next cycle.
- IDLE, start=1, op in {DIV, DIVU}:
  - Latch pl=quotient and ph=remainder.
  - Load count=DIV_CYCLES-1 and go to BUSY.
- IDLE, start=1, op=MTHI: hi<=src_a at the edge; no busy.
- IDLE, start=1, op=MTLO: lo<=src_a at the edge; no busy.
- IDLE, start=1, other op: no state change.
- BUSY:
  - If count != 0, decrement count.
  - If count == 0: hi<=ph, lo<=pl, go to IDLE. busy drops in the cycle after the commit edge.
  - busy is high for exactly N cycles (N = MULT_CYCLES or DIV_CYCLES).
  - New hi/lo are visible in the first cycle with busy=0.
- start while BUSY: ignored (including MTHI/MTLO). The pipeline does not issue it, since stall=1.
- start in the same cycle busy falls (first IDLE cycle): accepted normally.
- Arithmetic:
  - MULT: signed 32x32 -> 64-bit two's complement.
  - MULTU: unsigned 32x32 -> 64-bit.
  - DIV: quotient truncates toward zero; remainder takes the sign of the dividend.
  - DIVU: unsigned quotient and remainder.
- Division boundaries:
  - Divisor 0 (DIV or DIVU): full busy latency, then hi/lo unchanged (pending result discarded).
  - DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0x00000000. No trap.
- hi/lo never change except on a commit, MTHI/MTLO, or reset. During BUSY they hold their old values.

Test Plan:
- Reset then MULT, src_a=0xFFFFFFFD, src_b=5 -> busy high 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFF1; stall=1 in the start cycle and all busy cycles.
- MULTU, src_a=0xFFFFFFFF, src_b=2 -> after 5 busy cycles, hi=0x00000001, lo=0xFFFFFFFE.
- DIV, src_a=0xFFFFFFF9 (-7), src_b=2 -> busy 10 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU, src_a=7, src_b=2 -> lo=3, hi=1.
- DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0. DIVU x/0 with hi=0x11, lo=0x22 -> busy 10 cycles, hi/lo stay 0x11/0x22.
- MTHI 0xAAAA5555, then MTLO 0x12345678 on consecutive cycles -> hi and lo update the edge after each start, busy stays 0. MTLO issued during BUSY -> lo unchanged until commit, which writes the product.
- Start MULT, drive reset=0 on busy cycle 3 -> busy=0, hi=lo=0, no later commit. Start DIV in the first cycle after busy falls -> accepted, busy=1 the next cycle.

Source files
------------

// File: rtl/muldiv_seq.sv
// Fixed-latency multiply/divide unit that owns the HI/LO registers.
// The result is computed on start, then released onto hi/lo after the busy window expires.
module muldiv_seq #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES - 1);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES - 1);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [3:0]  count_q, count_d;
  logic [31:0] ph_q, ph_d;
  logic [31:0] pl_q, pl_d;
  logic        valid_q, valid_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic        is_mul, is_div, accept;
  logic [63:0] prod_s, prod_u;
  logic [31:0] div_b, abs_a, abs_b, qmag, rmag;
  logic [31:0] quot_s, rem_s, quot_u, rem_u;

  assign is_mul = (op == OP_MULT) || (op == OP_MULTU);
  assign is_div = (op == OP_DIV)  || (op == OP_DIVU);
  assign accept = start && (state_q == IDLE);

  // Arithmetic is evaluated in the accept cycle; the busy window only models latency.
  always_comb begin
    prod_s = {{32{src_a[31]}}, src_a} * {{32{src_b[31]}}, src_b};
    prod_u = {32'b0, src_a} * {32'b0, src_b};
    div_b  = (src_b == 32'd0) ? 32'd1 : src_b;
    abs_a  = src_a[31] ? (32'd0 - src_a) : src_a;
    abs_b  = div_b[31] ? (32'd0 - div_b) : div_b;
    qmag   = abs_a / abs_b;
    rmag   = abs_a % abs_b;
    // Magnitude form keeps 0x80000000 / -1 well defined: it wraps back to 0x80000000.
    quot_s = (src_a[31] ^ div_b[31]) ? (32'd0 - qmag) : qmag;
    rem_s  = src_a[31] ? (32'd0 - rmag) : rmag;
    quot_u = src_a / div_b;
    rem_u  = src_a % div_b;
  end

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      count_q <= 4'd0;
      ph_q    <= 32'd0;
      pl_q    <= 32'd0;
      valid_q <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      ph_q    <= ph_d;
      pl_q    <= pl_d;
      valid_q <= valid_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start && (is_mul || is_div)) state_d = BUSY;
      BUSY: if (count_q == 4'd0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    count_d = count_q;
    ph_d    = ph_q;
    pl_d    = pl_q;
    valid_d = valid_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    if (accept) begin
      case (op)
        OP_MULT: begin
          {ph_d, pl_d} = prod_s;
          valid_d      = 1'b1;
          count_d      = MULT_LOAD;
        end
        OP_MULTU: begin
          {ph_d, pl_d} = prod_u;
          valid_d      = 1'b1;
          count_d      = MULT_LOAD;
        end
        OP_DIV: begin
          pl_d    = quot_s;
          ph_d    = rem_s;
          valid_d = (src_b != 32'd0);
          count_d = DIV_LOAD;
        end
        OP_DIVU: begin
          pl_d    = quot_u;
          ph_d    = rem_u;
          valid_d = (src_b != 32'd0);
          count_d = DIV_LOAD;
        end
        OP_MTHI: hi_d = src_a;
        OP_MTLO: lo_d = src_a;
        default: ;
      endcase
    end else if (state_q == BUSY) begin
      if (count_q != 4'd0) begin
        count_d = count_q - 4'd1;
      end else begin
        // A zero divisor leaves valid clear, so the window expires with no write.
        if (valid_q) begin
          hi_d = ph_q;
          lo_d = pl_q;
        end
        valid_d = 1'b0;
      end
    end
  end

  // Output logic
  always_comb begin
    busy  = (state_q == BUSY);
    stall = start | busy;
    hi    = hi_q;
    lo    = lo_q;
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed vector table, hand-written corner
// sequences, and random operations checked against a plain-arithmetic model.
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] src_a, src_b;
  logic        busy, stall;
  logic [31:0] hi, lo;

  int n_pass  = 0;
  int n_total = 0;

  logic [31:0] ref_hi, ref_lo;

  muldiv_seq #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .src_a (src_a),
    .src_b (src_b),
    .busy  (busy),
    .stall (stall),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    int          exp_busy;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Reference model: architectural effect of one accepted operation.
  task automatic model(input logic [2:0] mop, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] eh, output logic [31:0] el, output int nb);
    longint      sa, sb, q, r, ps;
    logic [63:0] pu, pv;
    eh = ref_hi;
    el = ref_lo;
    nb = 0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (mop)
      3'd1: begin ps = sa * sb; pv = 64'(ps); eh = pv[63:32]; el = pv[31:0]; nb = 5; end
      3'd2: begin pu = 64'(a) * 64'(b); eh = pu[63:32]; el = pu[31:0]; nb = 5; end
      3'd3: begin
        nb = 10;
        if (b != 0) begin q = sa / sb; r = sa % sb; el = 32'(q); eh = 32'(r); end
      end
      3'd4: begin
        nb = 10;
        if (b != 0) begin el = a / b; eh = a % b; end
      end
      3'd5: eh = a;
      3'd6: el = a;
      default: ;
    endcase
    ref_hi = eh;
    ref_lo = el;
  endtask

  // Issue one op from a negedge, count busy cycles, check hold and final hi/lo.
  task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                        input int eb);
    logic [31:0] old_hi, old_lo;
    int n;
    bit held;
    old_hi = hi;
    old_lo = lo;
    start = 1'b1; op = o; src_a = a; src_b = b;
    #1;
    check({name, " stall_on_start"}, 32'(stall), 32'd1);
    @(negedge clk);
    start = 1'b0;
    n = 0;
    held = 1'b1;
    while (busy && n < 40) begin
      n++;
      if (hi !== old_hi || lo !== old_lo || stall !== 1'b1) held = 1'b0;
      @(negedge clk);
    end
    $display("op=%0d a=%08h b=%08h -> busy=%0d hi=%08h lo=%08h (%s)", o, a, b, n, hi, lo, name);
    check({name, " busy_cycles"}, 32'(n), 32'(eb));
    check({name, " hold_during_busy"}, 32'(held), 32'd1);
    check({name, " hi"}, hi, eh);
    check({name, " lo"}, lo, el);
  endtask

  initial begin
    logic [31:0] eh, el;
    int nb, n;
    logic [2:0] rop;
    logic [31:0] ra, rb;

    vecs[0]  = '{3'd1, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 5};
    vecs[1]  = '{3'd2, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE, 5};
    vecs[2]  = '{3'd3, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    vecs[3]  = '{3'd4, 32'd7,        32'd2,        32'h00000001, 32'h00000003, 10};
    vecs[4]  = '{3'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};
    vecs[5]  = '{3'd5, 32'h00000011, 32'd0,        32'h00000011, 32'h80000000, 0};
    vecs[6]  = '{3'd6, 32'h00000022, 32'd0,        32'h00000011, 32'h00000022, 0};
    vecs[7]  = '{3'd4, 32'd5,        32'd0,        32'h00000011, 32'h00000022, 10};
    vecs[8]  = '{3'd3, 32'd5,        32'd0,        32'h00000011, 32'h00000022, 10};
    vecs[9]  = '{3'd0, 32'h12345678, 32'd3,        32'h00000011, 32'h00000022, 0};
    vecs[10] = '{3'd7, 32'h12345678, 32'd3,        32'h00000011, 32'h00000022, 0};
    vecs[11] = '{3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 5};
    vecs[12] = '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5};
    vecs[13] = '{3'd4, 32'hFFFFFFFF, 32'd1,        32'h00000000, 32'hFFFFFFFF, 10};
    vecs[14] = '{3'd3, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10};

    reset = 1'b0; start = 1'b0; op = 3'd0; src_a = 32'd0; src_b = 32'd0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("reset busy", 32'(busy), 32'd0);
    check("reset stall", 32'(stall), 32'd0);
    check("reset hi", hi, 32'd0);
    check("reset lo", lo, 32'd0);

    for (int i = 0; i < 15; i++)
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
             vecs[i].exp_hi, vecs[i].exp_lo, vecs[i].exp_busy);
    ref_hi = hi_exp_last(); ref_lo = 32'hFFFFFFFD;

    // MTHI then MTLO on consecutive cycles
    start = 1'b1; op = 3'd5; src_a = 32'hAAAA5555;
    @(negedge clk);
    check("mthi hi", hi, 32'hAAAA5555);
    check("mthi busy", 32'(busy), 32'd0);
    op = 3'd6; src_a = 32'h12345678;
    @(negedge clk);
    start = 1'b0;
    check("mtlo lo", lo, 32'h12345678);
    check("mtlo hi_kept", hi, 32'hAAAA5555);
    check("mtlo busy", 32'(busy), 32'd0);
    $display("mthi/mtlo back-to-back -> hi=%08h lo=%08h", hi, lo);

    // MTLO during BUSY is ignored; the commit writes the product
    start = 1'b1; op = 3'd1; src_a = 32'd3; src_b = 32'd4;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; op = 3'd6; src_a = 32'hDEADBEEF;
    @(negedge clk);
    start = 1'b0;
    check("mtlo_in_busy lo_unchanged", lo, 32'h12345678);
    n = 2;
    while (busy && n < 40) begin n++; @(negedge clk); end
    $display("mult during-busy mtlo -> busy=%0d hi=%08h lo=%08h", n, hi, lo);
    check("mtlo_in_busy busy_cycles", 32'(n), 32'd5);
    check("mtlo_in_busy hi", hi, 32'd0);
    check("mtlo_in_busy lo", lo, 32'd12);

    // Reset on busy cycle 3 aborts the multiply
    start = 1'b1; op = 3'd1; src_a = 32'd100; src_b = 32'd100;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check("abort busy", 32'(busy), 32'd0);
    check("abort hi", hi, 32'd0);
    check("abort lo", lo, 32'd0);
    repeat (8) @(negedge clk);
    $display("reset mid-mult -> busy=%0d hi=%08h lo=%08h", busy, hi, lo);
    check("abort no_late_commit_lo", lo, 32'd0);
    check("abort no_late_busy", 32'(busy), 32'd0);
    ref_hi = 32'd0; ref_lo = 32'd0;

    // DIV started in the first idle cycle after a DIVU
    start = 1'b1; op = 3'd4; src_a = 32'd100; src_b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (busy && n < 40) begin n++; @(negedge clk); end
    check("b2b first_busy", 32'(n), 32'd10);
    check("b2b first_lo", lo, 32'd14);
    start = 1'b1; op = 3'd3; src_a = 32'd100; src_b = 32'hFFFFFFF9;
    @(negedge clk);
    start = 1'b0;
    check("b2b accepted_busy", 32'(busy), 32'd1);
    n = 0;
    while (busy && n < 40) begin n++; @(negedge clk); end
    $display("b2b div 100/-7 -> busy=%0d hi=%08h lo=%08h", n, hi, lo);
    check("b2b second_busy", 32'(n), 32'd10);
    check("b2b second_hi", hi, 32'd2);
    check("b2b second_lo", lo, 32'hFFFFFFF2);
    ref_hi = 32'd2; ref_lo = 32'hFFFFFFF2;

    // Random operations against the model
    for (int i = 0; i < 150; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      case ($urandom_range(0, 3))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 20));
        2: rb = 32'hFFFFFFFF;
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 9) == 0) ra = 32'h80000000;
      model(rop, ra, rb, eh, el, nb);
      run_op($sformatf("rand%0d", i), rop, ra, rb, eh, el, nb);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  function automatic logic [31:0] hi_exp_last();
    return 32'h00000001;
  endfunction

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
